// File: rtl/spi_regfile_pkg.sv
// Shared types and address-map helpers for the SPI register-file subnode.
package spi_regfile_pkg;

    typedef enum logic [2:0] {
        ST_CMD     = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_MODE = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RD_MODE = 3'd4,
        ST_RD_STAT = 3'd5,
        ST_IDLE    = 3'd6
    } state_e;

    // Command layout: MSB is read(1)/write(0), the remaining low bits are the address.
    function automatic int cmd_rw_bit(input int cmd_w);
        return cmd_w - 1;
    endfunction

    function automatic int cmd_addr_w(input int cmd_w);
        return cmd_w - 1;
    endfunction

    function automatic int mode_addr(input int num_regs);
        return num_regs;
    endfunction

    function automatic int stat_addr(input int num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with a one-flop rise/fall detector behind it.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= STAGES'({r_sync, i_d});
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_regfile_subnode.sv
// SPI mode-0 subnode exposing NUM_REGS data registers, a mode register and a
// read-only status word; the cipher core writes results back through wrback_*.
module spi_regfile_subnode
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 3,
    parameter int REG_W       = 128,
    parameter int MODE_W      = 3,
    parameter int CMD_W       = 5,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sck,
    input  logic                      csb,
    input  logic                      mosi,
    output logic                      miso,
    input  logic                      wrback_en,
    input  logic [SEL_W-1:0]          wrback_sel,
    input  logic [REG_W-1:0]          wrback_val,
    input  logic                      operation_done,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic [MODE_W-1:0]         operation_mode,
    output logic                      operation_ready,
    output logic                      err_flag
);

    localparam int AW     = cmd_addr_w(CMD_W);
    localparam int RW_BIT = cmd_rw_bit(CMD_W);
    localparam int MODE_A = mode_addr(NUM_REGS);
    localparam int STAT_A = stat_addr(NUM_REGS);
    localparam int STAT_W = MODE_W + 2;
    localparam int MAXW   = (REG_W > STAT_W) ? ((REG_W > CMD_W) ? REG_W : CMD_W)
                                             : ((STAT_W > CMD_W) ? STAT_W : CMD_W);
    localparam int CNT_W  = $clog2(MAXW);

    logic w_sck_q, w_sck_rise, w_sck_fall;
    logic w_csb_q, w_csb_rise, w_csb_fall;
    logic w_mosi;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    state_e r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [AW-1:0]    r_addr, w_addr_nx, w_dec_addr;
    logic [CMD_W-1:0] r_cmd, w_cmd_nx, w_cmd_sh;
    logic             r_miso, w_miso_nx;
    logic             w_spi_wr, w_mode_wr, w_mode_last, w_stat_done;
    logic [NUM_REGS-1:0][REG_W-1:0] r_regs;
    logic [MODE_W-1:0] r_mode;
    logic              r_ready, r_err;
    logic [MAXW-1:0]   w_rd_word;
    logic [SEL_W-1:0]  w_idx;
    logic              w_wb_ok, w_coll;
    logic              w_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .i_d(sck), .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb_sync (
        .clk(clk), .rst(rst), .i_d(csb), .o_q(w_csb_q), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    // mosi gets the same latency as sck so each sampled bit lines up with its rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mosi_sync <= '0;
        else     r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, mosi});
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_unused   = &{1'b0, w_sck_q, w_csb_rise, w_csb_fall, r_cmd[CMD_W-1]};
    assign w_cmd_sh   = {r_cmd[CMD_W-2:0], w_mosi};
    assign w_dec_addr = w_cmd_sh[AW-1:0];
    assign w_idx      = r_addr[SEL_W-1:0];
    assign w_wb_ok    = wrback_en && (32'(wrback_sel) < NUM_REGS);
    assign w_coll     = w_spi_wr && w_wb_ok && (wrback_sel == w_idx);

    always_comb begin
        w_rd_word = '0;
        case (r_state)
            ST_RD_DATA: w_rd_word = MAXW'(r_regs[w_idx]);
            ST_RD_MODE: w_rd_word = MAXW'(r_mode);
            ST_RD_STAT: w_rd_word = MAXW'({r_err, r_ready, r_mode});
            default:    ;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_addr_nx   = r_addr;
        w_cmd_nx    = r_cmd;
        w_miso_nx   = r_miso;
        w_spi_wr    = 1'b0;
        w_mode_wr   = 1'b0;
        w_mode_last = 1'b0;
        w_stat_done = 1'b0;
        if (w_csb_q) begin
            w_state_nx = ST_CMD;
            w_cnt_nx   = CNT_W'(CMD_W - 1);
            w_cmd_nx   = '0;
            w_miso_nx  = 1'b1;
        end else begin
            if (w_sck_rise) begin
                case (r_state)
                    ST_CMD: begin
                        w_cmd_nx = w_cmd_sh;
                        if (r_cnt == '0) begin
                            if (32'(w_dec_addr) < NUM_REGS) begin
                                w_state_nx = w_cmd_sh[RW_BIT] ? ST_RD_DATA : ST_WR_DATA;
                                w_cnt_nx   = CNT_W'(REG_W - 1);
                                w_addr_nx  = w_dec_addr;
                            end else if (32'(w_dec_addr) == MODE_A) begin
                                w_state_nx = w_cmd_sh[RW_BIT] ? ST_RD_MODE : ST_WR_MODE;
                                w_cnt_nx   = CNT_W'(MODE_W - 1);
                            end else if ((32'(w_dec_addr) == STAT_A) && w_cmd_sh[RW_BIT]) begin
                                w_state_nx = ST_RD_STAT;
                                w_cnt_nx   = CNT_W'(STAT_W - 1);
                            end else begin
                                w_state_nx = ST_IDLE;
                            end
                        end else begin
                            w_cnt_nx = r_cnt - 1'b1;
                        end
                    end
                    ST_WR_DATA, ST_RD_DATA: begin
                        w_spi_wr = (r_state == ST_WR_DATA);
                        if (r_cnt == '0) begin
                            // burst: roll into the next register until the last one
                            if (32'(r_addr) + 1 < NUM_REGS) begin
                                w_addr_nx = r_addr + 1'b1;
                                w_cnt_nx  = CNT_W'(REG_W - 1);
                            end else begin
                                w_state_nx = ST_IDLE;
                            end
                        end else begin
                            w_cnt_nx = r_cnt - 1'b1;
                        end
                    end
                    ST_WR_MODE, ST_RD_MODE, ST_RD_STAT: begin
                        w_mode_wr = (r_state == ST_WR_MODE);
                        if (r_cnt == '0) begin
                            w_mode_last = (r_state == ST_WR_MODE);
                            w_stat_done = (r_state == ST_RD_STAT);
                            w_state_nx  = ST_IDLE;
                        end else begin
                            w_cnt_nx = r_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_sck_fall) begin
                if (r_state inside {ST_RD_DATA, ST_RD_MODE, ST_RD_STAT})
                    w_miso_nx = w_rd_word[r_cnt];
                else
                    w_miso_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CMD;
            r_cnt   <= CNT_W'(CMD_W - 1);
            r_addr  <= '0;
            r_cmd   <= '0;
            r_miso  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_addr  <= w_addr_nx;
            r_cmd   <= w_cmd_nx;
            r_miso  <= w_miso_nx;
        end
    end

    // write-back has priority over an SPI shift into the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else begin
            if (w_spi_wr && !w_coll) r_regs[w_idx] <= {r_regs[w_idx][REG_W-2:0], w_mosi};
            if (w_wb_ok)             r_regs[wrback_sel] <= wrback_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_mode_wr) r_mode <= {r_mode[MODE_W-2:0], w_mosi};
            if (operation_done)   r_ready <= 1'b0;
            else if (w_mode_last) r_ready <= 1'b1;
            if (w_coll)           r_err <= 1'b1;
            else if (w_stat_done) r_err <= 1'b0;
        end
    end

    assign miso            = r_miso;
    assign regs_flat       = r_regs;
    assign operation_mode  = r_mode;
    assign operation_ready = r_ready;
    assign err_flag        = r_err;

endmodule
